time_set_rx: RTL and testbench
==============================

// Module: time_set_rx
// PURPOSE
//  Serial time-set receiver for the century clock. Deserialises a UART 8N1 frame carrying BCD time/date,
//  validates it (BCD, ranges, month length, leap year, XOR checksum) and presents registered BCD fields
//  plus a one-cycle load strobe that presets the sec..year counters. Runs on the system clock (pre-divider).
// PARAMETERS
//  F_IN   50_000_000  system clock frequency, Hz
//  BAUD   115_200     serial bit rate; CLKS_PER_BIT = F_IN/BAUD (integer division), must be >= 4
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  rx          in   1  serial input, idle high, asynchronous to clk
//  load        out  1  one-cycle pulse: fields below hold a newly accepted time/date
//  sec_unit    out  4  BCD;  sec_ten    out 4
//  min_unit    out  4  BCD;  min_ten    out 4
//  hour_unit   out  4  BCD;  hour_ten   out 2
//  day_unit    out  4  BCD;  day_ten    out 2
//  month_unit  out  4  BCD;  month_ten  out 2
//  year_thou, year_hund, year_ten, year_unit  out 4 each, BCD
//  frame_err   out  1  one-cycle pulse: frame rejected
//  busy        out  1  high from header byte accepted until frame accept/reject
// BEHAVIOUR
//  Reset: load=0, frame_err=0, busy=0, fields = 00:00:00 01/01/2000, both FSMs idle.
//  rx passes a 2-flop synchroniser (reset value 1) before use.
//  Bit FSM: IDLE -(sync rx=0)-> START; at CLKS_PER_BIT/2 resample: 0 -> DATA, 1 -> IDLE (glitch, no byte).
//   DATA: 8 samples at mid-bit, LSB first -> STOP; STOP mid-bit sample 1 = byte valid, 0 = framing error.
//   After STOP, back to IDLE (start detection re-armed immediately; no extra idle time needed).
//  Frame: A5, SS, MM, HH, DD, MO, YH, YL, CK (9 bytes); YH = century BCD, YL = year-in-century BCD.
//  Byte FSM: WAIT_HDR (non-A5 bytes ignored, no error) -> COLLECT idx 0..7; A5 inside a frame is data.
//  Checks (all on payload, after CK received):
//   - every nibble <= 9; SS,MM <= 59; HH <= 23; MO 01..12; DD >= 01
//   - DD <= 31 for months 1,3,5,7,8,10,12; <= 30 for months 4,6,9,11; Feb: <= 29 if leap, else <= 28
//   - leap: YL != 00 and YL%4==0, or YL == 00 and YH%4==0 (BCD%4==0: ten even & unit in {0,4,8},
//     or ten odd & unit in {2,6})
//   - CK == SS^MM^HH^DD^MO^YH^YL
//  Accept: fields update and load=1 in the same cycle, exactly one clk after the CK stop-bit sample.
//  Reject (any check fails, framing error on any byte, or inter-byte timeout): frame_err=1 for one cycle,
//   fields unchanged, load stays 0, FSM -> WAIT_HDR. On framing error, reject is immediate (rest ignored).
//  Timeout: inside a frame, 20*CLKS_PER_BIT clks from one stop-bit sample to the next start edge -> reject.
//  load and frame_err never assert in the same cycle. busy drops in the same cycle as load/frame_err.
//  rst_n low mid-frame: all state and outputs return to reset values immediately; partial frame discarded.
//  Header-only or truncated frames never update fields.
// TESTING (bench F_IN=1_000_000, BAUD=100_000 -> 10 clks/bit)
//  A5 30 59 23 31 12 20 99 D0 -> single load pulse; fields 23:59:30 31/12/2099; frame_err stays 0
//  same frame with CK=D1 -> frame_err pulse, no load, fields keep previous values
//  29/02 with YH/YL 20/24 accepted, 20/23 rejected, 20/00 accepted, 21/00 rejected
//  31/04, SS=60, HH=24, MO=00, DD=00, nibble 0xA in MM -> each frame_err; 30/04 accepted
//  stop bit forced low on byte HH -> immediate frame_err; next valid frame accepted
//  rx low pulse of 3 clks in IDLE -> no byte, no error; 250-clk gap after MO -> timeout frame_err
//  rst_n pulsed after 4 bytes -> fields 00:00:00 01/01/2000, busy=0; following full frame accepted

Source files
------------

// File: rtl/time_set_rx.sv
// time_set_rx: UART 8N1 receiver for BCD time/date preset frames.
// Frame A5,SS,MM,HH,DD,MO,YH,YL,CK is validated, then load strobes new fields.
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   rx                 serial input, idle high, asynchronous
//   load               1-cycle pulse, fields hold a newly accepted time/date
//   sec/min/hour/day/month/year_*   registered BCD fields
//   frame_err          1-cycle pulse, frame rejected
//   busy               header seen, frame still pending
module time_set_rx #(
  parameter int F_IN = 50_000_000,
  parameter int BAUD = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       load,
  output logic [3:0] sec_unit,
  output logic [3:0] sec_ten,
  output logic [3:0] min_unit,
  output logic [3:0] min_ten,
  output logic [3:0] hour_unit,
  output logic [1:0] hour_ten,
  output logic [3:0] day_unit,
  output logic [1:0] day_ten,
  output logic [3:0] month_unit,
  output logic [1:0] month_ten,
  output logic [3:0] year_thou,
  output logic [3:0] year_hund,
  output logic [3:0] year_ten,
  output logic [3:0] year_unit,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB = F_IN / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int TW  = $clog2(20 * CPB);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(20 * CPB - 1);

  typedef enum logic [1:0] {
    B_IDLE, B_START, B_DATA, B_STOP
  } bit_st_e;

  typedef enum logic {
    F_HDR, F_COLLECT
  } frm_st_e;

  // rx synchroniser
  logic rx_s1_q, rx_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // bit level receiver
  bit_st_e       bst_q, bst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    sh_q, sh_d;
  logic          start_edge;
  logic          byte_ok;
  logic          byte_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst_q  <= B_IDLE;
      cnt_q  <= '0;
      bitn_q <= '0;
      sh_q   <= '0;
    end else begin
      bst_q  <= bst_d;
      cnt_q  <= cnt_d;
      bitn_q <= bitn_d;
      sh_q   <= sh_d;
    end
  end

  always_comb begin
    bst_d      = bst_q;
    cnt_d      = cnt_q;
    bitn_d     = bitn_q;
    sh_d       = sh_q;
    start_edge = 1'b0;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
    unique case (bst_q)
      B_IDLE: begin
        if (!rx_s2_q) begin
          bst_d      = B_START;
          cnt_d      = '0;
          start_edge = 1'b1;
        end
      end
      B_START: begin
        if (cnt_q == HALF_M1) begin
          // start bit re-checked mid-bit to reject glitches
          cnt_d  = '0;
          bitn_d = '0;
          bst_d  = rx_s2_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d  = '0;
          sh_d   = {rx_s2_q, sh_q[7:1]};
          bitn_d = bitn_q + 1'b1;
          if (bitn_q == 3'd7)
            bst_d = B_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_STOP: begin
        if (cnt_q == CPB_M1) begin
          bst_d    = B_IDLE;
          cnt_d    = '0;
          byte_ok  = rx_s2_q;
          byte_bad = !rx_s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // payload checks; pay_q holds SS at [7:0] up to YL at [55:48]
  logic [55:0] pay_q, pay_d;
  logic [7:0]  ss, mm, hh, dd, mo, yh, yl;
  logic        nib_ok;
  logic        leap;
  logic        mo30;
  logic [7:0]  dd_max;
  logic        frame_good;

  assign ss = pay_q[7:0];
  assign mm = pay_q[15:8];
  assign hh = pay_q[23:16];
  assign dd = pay_q[31:24];
  assign mo = pay_q[39:32];
  assign yh = pay_q[47:40];
  assign yl = pay_q[55:48];

  function automatic logic div4(input logic [4:0] b);
    if (b[4])
      return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
    return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) ||
           (b[3:0] == 4'd8);
  endfunction

  always_comb begin
    nib_ok = 1'b1;
    for (int i = 0; i < 14; i++)
      if (pay_q[4*i +: 4] > 4'd9)
        nib_ok = 1'b0;
  end

  assign leap = (yl != 8'h00) ? div4(yl[4:0])
                              : div4(yh[4:0]);

  assign mo30 = (mo == 8'h04) || (mo == 8'h06) ||
                (mo == 8'h09) || (mo == 8'h11);

  always_comb begin
    dd_max = 8'h31;
    unique case (1'b1)
      mo == 8'h02: dd_max = leap ? 8'h29 : 8'h28;
      mo30:        dd_max = 8'h30;
      default:     dd_max = 8'h31;
    endcase
  end

  // sh_q carries CK while its stop bit is being accepted;
  // raw compares are valid BCD compares once nib_ok holds
  assign frame_good = nib_ok &&
                      (ss <= 8'h59) && (mm <= 8'h59) &&
                      (hh <= 8'h23) &&
                      (mo >= 8'h01) && (mo <= 8'h12) &&
                      (dd >= 8'h01) && (dd <= dd_max) &&
                      (sh_q == (ss ^ mm ^ hh ^ dd ^ mo ^ yh ^ yl));

  // frame level
  frm_st_e       fst_q, fst_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          load_q, load_d;
  logic          err_q, err_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [5:0]    hour_q, hour_d;
  logic [5:0]    day_q, day_d;
  logic [5:0]    mon_q, mon_d;
  logic [15:0]   year_q, year_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fst_q  <= F_HDR;
      idx_q  <= '0;
      pay_q  <= '0;
      tmo_q  <= '0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hour_q <= 6'h00;
      day_q  <= 6'h01;
      mon_q  <= 6'h01;
      year_q <= 16'h2000;
    end else begin
      fst_q  <= fst_d;
      idx_q  <= idx_d;
      pay_q  <= pay_d;
      tmo_q  <= tmo_d;
      load_q <= load_d;
      err_q  <= err_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      day_q  <= day_d;
      mon_q  <= mon_d;
      year_q <= year_d;
    end
  end

  always_comb begin
    fst_d  = fst_q;
    idx_d  = idx_q;
    pay_d  = pay_q;
    tmo_d  = tmo_q;
    load_d = 1'b0;
    err_d  = 1'b0;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    day_d  = day_q;
    mon_d  = mon_q;
    year_d = year_q;
    unique case (fst_q)
      F_HDR: begin
        if (byte_ok && sh_q == 8'hA5) begin
          fst_d = F_COLLECT;
          idx_d = '0;
          tmo_d = '0;
        end
      end
      F_COLLECT: begin
        if (byte_bad) begin
          err_d = 1'b1;
          fst_d = F_HDR;
        end else if (byte_ok) begin
          tmo_d = '0;
          if (idx_q == 3'd7) begin
            fst_d = F_HDR;
            if (frame_good) begin
              load_d = 1'b1;
              sec_d  = ss;
              min_d  = mm;
              hour_d = hh[5:0];
              day_d  = dd[5:0];
              mon_d  = mo[5:0];
              year_d = {yh, yl};
            end else begin
              err_d = 1'b1;
            end
          end else begin
            pay_d = {sh_q, pay_q[55:8]};
            idx_d = idx_q + 1'b1;
          end
        end else if (start_edge) begin
          tmo_d = '0;
        end else if (bst_q == B_IDLE) begin
          // line idle between bytes of an open frame
          if (tmo_q == TMO_M1) begin
            err_d = 1'b1;
            fst_d = F_HDR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign load       = load_q;
  assign frame_err  = err_q;
  assign busy       = (fst_q == F_COLLECT);
  assign sec_unit   = sec_q[3:0];
  assign sec_ten    = sec_q[7:4];
  assign min_unit   = min_q[3:0];
  assign min_ten    = min_q[7:4];
  assign hour_unit  = hour_q[3:0];
  assign hour_ten   = hour_q[5:4];
  assign day_unit   = day_q[3:0];
  assign day_ten    = day_q[5:4];
  assign month_unit = mon_q[3:0];
  assign month_ten  = mon_q[5:4];
  assign year_thou  = year_q[15:12];
  assign year_hund  = year_q[11:8];
  assign year_ten   = year_q[7:4];
  assign year_unit  = year_q[3:0];

endmodule

// File: tb/tb_time_set_rx.sv
// tb_time_set_rx: directed and random frames against a byte-level
// reference model of the time-set frame rules.
module tb_time_set_rx;

  localparam int F_IN = 1_000_000;
  localparam int BAUD = 100_000;
  localparam int CPB  = F_IN / BAUD;
  localparam logic [55:0] RST_F =
    {8'h20, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       load, frame_err, busy;
  logic [3:0] sec_unit, sec_ten, min_unit, min_ten;
  logic [3:0] hour_unit, day_unit, month_unit;
  logic [1:0] hour_ten, day_ten, month_ten;
  logic [3:0] year_thou, year_hund, year_ten, year_unit;

  time_set_rx #(.F_IN(F_IN), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .load(load),
    .sec_unit(sec_unit), .sec_ten(sec_ten),
    .min_unit(min_unit), .min_ten(min_ten),
    .hour_unit(hour_unit), .hour_ten(hour_ten),
    .day_unit(day_unit), .day_ten(day_ten),
    .month_unit(month_unit), .month_ten(month_ten),
    .year_thou(year_thou), .year_hund(year_hund),
    .year_ten(year_ten), .year_unit(year_unit),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int load_cnt = 0, err_cnt = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (load)             load_cnt <= load_cnt + 1;
    if (frame_err)        err_cnt  <= err_cnt + 1;
    if (load & frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // reference model: byte stream in, expected counts and fields out
  bit          m_in = 1'b0;
  logic [7:0]  m_buf[$];
  logic [55:0] m_f = RST_F;
  int          m_load = 0, m_err = 0, idle_acc = 0;

  function automatic int bval(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int days_in(input int mo, input int yr);
    bit lp;
    lp = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
    case (mo)
      2:           return lp ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  function automatic bit m_valid();
    logic [7:0] x;
    int s, m, h, d, mo, yr;
    x = 8'h00;
    for (int i = 0; i < 7; i++) begin
      if (m_buf[i][7:4] > 9 || m_buf[i][3:0] > 9) return 1'b0;
      x ^= m_buf[i];
    end
    if (x != m_buf[7]) return 1'b0;
    s  = bval(m_buf[0]);
    m  = bval(m_buf[1]);
    h  = bval(m_buf[2]);
    d  = bval(m_buf[3]);
    mo = bval(m_buf[4]);
    yr = bval(m_buf[5]) * 100 + bval(m_buf[6]);
    if (s > 59 || m > 59 || h > 23) return 1'b0;
    if (mo < 1 || mo > 12 || d < 1) return 1'b0;
    return d <= days_in(mo, yr);
  endfunction

  task automatic m_byte(input logic [7:0] b, input bit ok);
    if (!m_in) begin
      if (ok && b == 8'hA5) begin
        m_in = 1'b1;
        m_buf.delete();
      end
    end else if (!ok) begin
      m_in = 1'b0;
      m_err++;
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 8) begin
        m_in = 1'b0;
        if (m_valid()) begin
          m_load++;
          m_f = {m_buf[5], m_buf[6], m_buf[4], m_buf[3],
                 m_buf[2], m_buf[1], m_buf[0]};
        end else begin
          m_err++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    idle_acc += n;
    if (m_in && idle_acc > 150) begin
      m_in = 1'b0;
      m_err++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    idle_acc = 0;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    m_byte(b, ok);
    if (!ok) idle(20);
  endtask

  function automatic logic [55:0] dut_f();
    return {year_thou, year_hund, year_ten, year_unit,
            2'b00, month_ten, month_unit,
            2'b00, day_ten, day_unit,
            2'b00, hour_ten, hour_unit,
            min_ten, min_unit, sec_ten, sec_unit};
  endfunction

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m_in = 1'b0;
    m_buf.delete();
    m_f = RST_F;
    check({tag, ".rst_fields"}, 64'(dut_f()), 64'(RST_F));
    check({tag, ".rst_busy"}, 64'(busy), 64'(0));
    rst_n = 1'b1;
    idle_acc = 0;
    idle(3);
  endtask

  task automatic settle(input string tag);
    idle(30);
    check({tag, ".load"}, 64'(load_cnt), 64'(m_load));
    check({tag, ".err"}, 64'(err_cnt), 64'(m_err));
    check({tag, ".fields"}, 64'(dut_f()), 64'(m_f));
    check({tag, ".busy"}, 64'(busy), 64'(m_in));
  endtask

  function automatic logic [71:0] fix_ck(input logic [71:0] fr);
    logic [7:0] x;
    x = 8'h00;
    for (int j = 1; j < 8; j++) x ^= fr[8*(8-j) +: 8];
    fr[7:0] = x;
    return fr;
  endfunction

  function automatic logic [71:0] mk_raw(
    input logic [7:0] s, m, h, d, mo, yh, yl, ckx);
    logic [71:0] fr;
    fr = fix_ck({8'hA5, s, m, h, d, mo, yh, yl, 8'h00});
    fr[7:0] ^= ckx;
    return fr;
  endfunction

  function automatic logic [71:0] mk(
    input int s, m, h, d, mo, yr, input logic [7:0] ckx);
    return mk_raw(bcd(s), bcd(m), bcd(h), bcd(d), bcd(mo),
                  bcd(yr / 100), bcd(yr % 100), ckx);
  endfunction

  // bad_i: byte with low stop bit; gap_i: long idle after that
  // byte; rst_i: reset instead of sending that byte
  task automatic send_frame(input string tag, input logic [71:0] fr,
                            input int bad_i, input int gap_i,
                            input int rst_i);
    for (int i = 0; i < 9; i++) begin
      if (i == rst_i) begin
        do_reset(tag);
        break;
      end
      send_byte(fr[8*(8-i) +: 8], i != bad_i);
      if (i == gap_i) idle(250);
      else idle($urandom_range(0, 4));
    end
    settle(tag);
  endtask

  initial begin
    logic [71:0] fr;
    int yr, mo, dd, kind, j;

    repeat (3) @(negedge clk);
    check("reset.load", 64'(load), 64'(0));
    check("reset.err", 64'(frame_err), 64'(0));
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.fields", 64'(dut_f()), 64'(RST_F));
    rst_n = 1'b1;
    idle(5);

    send_frame("y2099", mk(30, 59, 23, 31, 12, 2099, 8'h00),
               -1, -1, -1);
    check("y2099.ck", 64'(fr_ck_d0()), 64'(8'hD0));
    send_frame("badck", mk(30, 59, 23, 31, 12, 2099, 8'h01),
               -1, -1, -1);
    send_frame("feb2024", mk(1, 2, 3, 29, 2, 2024, 8'h00), -1, -1, -1);
    send_frame("feb2023", mk(1, 2, 3, 29, 2, 2023, 8'h00), -1, -1, -1);
    send_frame("feb2000", mk(4, 5, 6, 29, 2, 2000, 8'h00), -1, -1, -1);
    send_frame("feb2100", mk(4, 5, 6, 29, 2, 2100, 8'h00), -1, -1, -1);
    send_frame("apr31", mk(0, 0, 12, 31, 4, 2024, 8'h00), -1, -1, -1);
    send_frame("ss60", mk(60, 0, 12, 1, 5, 2024, 8'h00), -1, -1, -1);
    send_frame("hh24", mk(0, 0, 24, 1, 5, 2024, 8'h00), -1, -1, -1);
    send_frame("mo00", mk(0, 0, 12, 1, 0, 2024, 8'h00), -1, -1, -1);
    send_frame("dd00", mk(0, 0, 12, 0, 5, 2024, 8'h00), -1, -1, -1);
    send_frame("nibA", mk_raw(8'h00, 8'h5A, 8'h12, 8'h01, 8'h05,
               8'h20, 8'h24, 8'h00), -1, -1, -1);
    send_frame("apr30", mk(7, 8, 9, 30, 4, 2024, 8'h00), -1, -1, -1);
    send_frame("stop_hh", mk(11, 22, 13, 14, 6, 2031, 8'h00),
               3, -1, -1);
    send_frame("after_stop", mk(11, 22, 13, 14, 6, 2031, 8'h00),
               -1, -1, -1);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    settle("glitch");

    send_frame("timeout", mk(30, 59, 23, 31, 12, 2099, 8'h00),
               -1, 5, -1);
    send_frame("rst_mid", mk(1, 1, 1, 1, 1, 1999, 8'h00), -1, -1, 4);
    send_frame("after_rst", mk(45, 17, 8, 15, 7, 1969, 8'h00),
               -1, -1, -1);

    for (int n = 0; n < 24; n++) begin
      yr = $urandom_range(0, 9999);
      mo = $urandom_range(1, 12);
      dd = $urandom_range(1, days_in(mo, yr));
      fr = mk($urandom_range(0, 59), $urandom_range(0, 59),
              $urandom_range(0, 23), dd, mo, yr, 8'h00);
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        j = $urandom_range(1, 7);
        fr[8*(8-j) +: 8] = 8'($urandom_range(0, 255));
        fr = fix_ck(fr);
      end else if (kind == 1) begin
        fr[7:0] ^= 8'($urandom_range(1, 255));
      end else if (kind == 3) begin
        fr = mk(0, 0, 0, days_in(mo, yr) + 1, mo, yr, 8'h00);
      end else if (kind == 4) begin
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        idle(2);
      end
      send_frame("rand", fr, (kind == 2) ? $urandom_range(0, 8) : -1,
                 -1, -1);
    end

    check("both_pulses", 64'(both_cnt), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  function automatic logic [7:0] fr_ck_d0();
    logic [71:0] f;
    f = mk(30, 59, 23, 31, 12, 2099, 8'h00);
    return f[7:0];
  endfunction

endmodule
